issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_pkg.sv | 28 ++
 rtl/issue_scoreboard.sv | 64 ++++++
 rtl/issue_queue.sv | 160 ++++++++++++++++
 tb/tb_issue_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared definitions for the in-order issue queue.
// Holds functional-unit codes, default parameter values and the per-entry
// control flag struct. Register addresses and the payload are stored in
// separately sized arrays, because their widths follow module parameters.
package issue_pkg;

    // Functional unit codes carried on id_fu / iss_fu
    typedef enum logic [1:0] {
        FU_ALUMISC = 2'd0,
        FU_MEM     = 2'd1,
        FU_MUL     = 2'd2,
        FU_NONE    = 2'd3
    } fu_e;

    localparam int unsigned DEFAULT_DEPTH     = 4;
    localparam int unsigned DEFAULT_NUM_REGS  = 32;
    localparam int unsigned DEFAULT_NUM_FU    = 3;
    localparam int unsigned DEFAULT_PAYLOAD_W = 96;

    // Per-entry control flags; these have the same width in every configuration
    typedef struct packed {
        logic       usea;
        logic       useb;
        logic       writereg;
        logic [1:0] fu;
    } iq_ctrl_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Register pending-write scoreboard.
// Ports: clock/reset (async, active low); set_valid/set_addr marks a register
// as pending; clr_valid/clr_addr clears it on writeback (set wins on a
// collision); addr_a/addr_b/addr_d are looked up and hit_*_c report
// combinationally whether each is pending. Register 0 is never pending.
// Build option: ISSUE_WB_BYPASS_EN lets a same-cycle writeback hide the hit.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter  int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    localparam int unsigned REG_W    = $clog2(NUM_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_valid,
    input  logic [REG_W-1:0] set_addr,
    input  logic             clr_valid,
    input  logic [REG_W-1:0] clr_addr,
    input  logic [REG_W-1:0] addr_a,
    input  logic [REG_W-1:0] addr_b,
    input  logic [REG_W-1:0] addr_d,
    output logic             hit_a_c,
    output logic             hit_b_c,
    output logic             hit_d_c
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Clear first so that a same-edge set of the same register takes priority
    always_comb begin
        pending_nxt = pending;
        if (clr_valid) begin
            pending_nxt[clr_addr] = 1'b0;
        end
        if (set_valid && (set_addr != '0)) begin
            pending_nxt[set_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Lookups
    always_comb begin
        hit_a_c = pending[addr_a];
        hit_b_c = pending[addr_b];
        hit_d_c = pending[addr_d];
`ifdef ISSUE_WB_BYPASS_EN
        // A writeback landing this cycle already resolves the hazard
        if (clr_valid && (clr_addr == addr_a)) hit_a_c = 1'b0;
        if (clr_valid && (clr_addr == addr_b)) hit_b_c = 1'b0;
        if (clr_valid && (clr_addr == addr_d)) hit_d_c = 1'b0;
`else
`endif
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: a FIFO of decoded instructions whose head issues once
// its sources and its destination are free of pending writes and its target
// functional unit is ready.
// Ports: clock, reset (async, active low); id_* decode handshake and fields;
// fu_ready per-unit availability; wb_valid/wb_addr writeback; flush drops all
// queued entries; iss_* registered one-cycle issue pulse; iss_stall
// (combinational) head blocked; count occupancy.
// Build option: ISSUE_WB_BYPASS_EN (same-cycle writeback wakeup).
module issue_queue
    import issue_pkg::*;
#(
    parameter  int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter  int unsigned NUM_REGS  = DEFAULT_NUM_REGS,
    parameter  int unsigned NUM_FU    = DEFAULT_NUM_FU,
    parameter  int unsigned PAYLOAD_W = DEFAULT_PAYLOAD_W,
    localparam int unsigned REG_W     = $clog2(NUM_REGS),
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned PTR_W     = IDX_W + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REG_W-1:0]     id_addra,
    input  logic [REG_W-1:0]     id_addrb,
    input  logic                 id_usea,
    input  logic                 id_useb,
    input  logic [REG_W-1:0]     id_regdest,
    input  logic                 id_writereg,
    input  logic [1:0]           id_fu,
    input  logic [PAYLOAD_W-1:0] id_payload,
    input  logic [NUM_FU-1:0]    fu_ready,
    input  logic                 wb_valid,
    input  logic [REG_W-1:0]     wb_addr,
    input  logic                 flush,
    output logic                 iss_valid,
    output logic [1:0]           iss_fu,
    output logic [REG_W-1:0]     iss_regdest,
    output logic [PAYLOAD_W-1:0] iss_payload,
    output logic                 iss_stall,
    output logic [PTR_W-1:0]     count
);

    iq_ctrl_t             ctrl_mem    [DEPTH];
    logic [REG_W-1:0]     addra_mem   [DEPTH];
    logic [REG_W-1:0]     addrb_mem   [DEPTH];
    logic [REG_W-1:0]     dest_mem    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             empty;
    logic             full;
    logic             do_accept;
    logic             do_issue;
    logic             can_issue;
    logic             fu_ok;
    logic             hit_a;
    logic             hit_b;
    logic             hit_d;
    iq_ctrl_t         head_ctrl;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);

    // Readiness depends only on occupancy, not on a same-cycle issue
    assign id_ready  = !full;
    assign do_accept = id_valid && !full && !flush;

    assign head_ctrl = ctrl_mem[rd_idx];

    // Codes without a matching unit bypass the readiness check
    always_comb begin
        fu_ok = 1'b1;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            if (head_ctrl.fu == 2'(i)) begin
                fu_ok = fu_ready[i];
            end
        end
    end

    issue_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clock     (clock),
        .reset     (reset),
        .set_valid (do_issue && head_ctrl.writereg),
        .set_addr  (dest_mem[rd_idx]),
        .clr_valid (wb_valid),
        .clr_addr  (wb_addr),
        .addr_a    (addra_mem[rd_idx]),
        .addr_b    (addrb_mem[rd_idx]),
        .addr_d    (dest_mem[rd_idx]),
        .hit_a_c   (hit_a),
        .hit_b_c   (hit_b),
        .hit_d_c   (hit_d)
    );

    // Head issue decision: RAW on used sources, WAW on written destination
    assign can_issue = !empty
                     && !(head_ctrl.usea && hit_a)
                     && !(head_ctrl.useb && hit_b)
                     && !(head_ctrl.writereg && hit_d)
                     && fu_ok;
    assign do_issue  = can_issue && !flush;
    assign iss_stall = !empty && !can_issue;

    // Entry storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clock) begin
        if (do_accept) begin
            ctrl_mem[wr_idx]    <= '{usea: id_usea, useb: id_useb,
                                     writereg: id_writereg, fu: id_fu};
            addra_mem[wr_idx]   <= id_addra;
            addrb_mem[wr_idx]   <= id_addrb;
            dest_mem[wr_idx]    <= id_regdest;
            payload_mem[wr_idx] <= id_payload;
        end
    end

    // Pointers, occupancy and the registered issue port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            iss_valid   <= 1'b0;
            iss_fu      <= 2'(FU_NONE);
            iss_regdest <= '0;
            iss_payload <= '0;
        end else begin
            iss_valid <= do_issue;
            if (do_issue) begin
                iss_fu      <= head_ctrl.fu;
                iss_regdest <= dest_mem[rd_idx];
                iss_payload <= payload_mem[rd_idx];
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            if (flush) begin
                wr_ptr <= rd_ptr;
                count  <= '0;
            end else begin
                if (do_accept) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_accept && !do_issue) begin
                    count <= count + PTR_W'(1);
                end else if (!do_accept && do_issue) begin
                    count <= count - PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (default parameters).
// Follows ISSUE_WB_BYPASS_EN for the writeback wakeup timing.
module tb_issue_queue;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned NUM_FU    = 3;
    localparam int unsigned PAYLOAD_W = 96;
`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 id_valid;
    logic                 id_ready;
    logic [4:0]           id_addra;
    logic [4:0]           id_addrb;
    logic                 id_usea;
    logic                 id_useb;
    logic [4:0]           id_regdest;
    logic                 id_writereg;
    logic [1:0]           id_fu;
    logic [PAYLOAD_W-1:0] id_payload;
    logic [NUM_FU-1:0]    fu_ready;
    logic                 wb_valid;
    logic [4:0]           wb_addr;
    logic                 flush;
    logic                 iss_valid;
    logic [1:0]           iss_fu;
    logic [4:0]           iss_regdest;
    logic [PAYLOAD_W-1:0] iss_payload;
    logic                 iss_stall;
    logic [2:0]           count;

    int n_cmp;
    int n_err;

    issue_queue #(
        .DEPTH(DEPTH), .NUM_REGS(NUM_REGS), .NUM_FU(NUM_FU), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_addra(id_addra), .id_addrb(id_addrb),
        .id_usea(id_usea), .id_useb(id_useb),
        .id_regdest(id_regdest), .id_writereg(id_writereg),
        .id_fu(id_fu), .id_payload(id_payload),
        .fu_ready(fu_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flush(flush),
        .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_regdest(iss_regdest),
        .iss_payload(iss_payload), .iss_stall(iss_stall), .count(count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_addra = '0; id_addrb = '0; id_usea = 1'b0; id_useb = 1'b0;
        id_regdest = '0; id_writereg = 1'b0; id_fu = 2'd0; id_payload = '0;
        wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    endtask

    task automatic offer(input logic [4:0] a, input logic [4:0] b, input logic ua,
                         input logic ub, input logic [4:0] d, input logic wr,
                         input logic [1:0] fu, input logic [PAYLOAD_W-1:0] p);
        id_valid = 1'b1; id_addra = a; id_addrb = b; id_usea = ua; id_useb = ub;
        id_regdest = d; id_writereg = wr; id_fu = fu; id_payload = p;
    endtask

    task automatic do_reset();
        idle();
        fu_ready = 3'b111;
        reset = 1'b0;
        #2;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); fu_ready = 3'b000;
        tick(); tick();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL rst_iss_valid: got %b want 0", iss_valid); end
        n_cmp++; if (iss_fu !== 2'b11) begin n_err++; $display("FAIL rst_iss_fu: got %b want 11", iss_fu); end
        n_cmp++; if (iss_regdest !== 5'd0) begin n_err++; $display("FAIL rst_iss_regdest: got %0d want 0", iss_regdest); end
        n_cmp++; if (iss_payload !== '0) begin n_err++; $display("FAIL rst_iss_payload: got %h want 0", iss_payload); end
        n_cmp++; if (dut.u_sb.pending !== 32'h0) begin n_err++; $display("FAIL rst_pending: got %h want 0", dut.u_sb.pending); end
        n_cmp++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", iss_stall); end
        // Fill two entries, then reset mid-cycle: entries vanish at once
        reset = 1'b1;
        offer(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 2'd0, 96'h1);
        tick(); tick();
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL rst_pre_count: got %0d want 2", count); end
        idle();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_async_count: got %0d want 0", count); end
        n_cmp++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL rst_async_stall: got %b want 0", iss_stall); end
        tick();
        reset = 1'b1;
        offer(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 2'd0, 96'h2);
        tick();
        idle();
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL rst_first_accept: got %0d want 1", count); end
    endtask

    task automatic test_basic();
        do_reset();
        offer(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'd0, 96'hDEAD_BEEF_0123_4567_89AB_CDEF);
        tick();
        idle();
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", count); end
        n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", iss_valid); end
        tick();
        n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL basic_iss_valid: got %b want 1", iss_valid); end
        n_cmp++; if (iss_regdest !== 5'd3) begin n_err++; $display("FAIL basic_regdest: got %0d want 3", iss_regdest); end
        n_cmp++; if (iss_fu !== 2'd0) begin n_err++; $display("FAIL basic_fu: got %0d want 0", iss_fu); end
        n_cmp++; if (iss_payload !== 96'hDEAD_BEEF_0123_4567_89AB_CDEF) begin n_err++; $display("FAIL basic_payload: got %h", iss_payload); end
        n_cmp++; if (dut.u_sb.pending[3] !== 1'b1) begin n_err++; $display("FAIL basic_pending3: got %b want 1", dut.u_sb.pending[3]); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL basic_count_after: got %0d want 0", count); end
        tick();
        n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got %b want 0", iss_valid); end
    endtask

    task automatic test_raw();
        do_reset();
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'd0, 96'h11);
        tick();
        offer(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'd1, 96'h22);
        tick();
        idle();
        n_cmp++; if (iss_regdest !== 5'd5) begin n_err++; $display("FAIL raw_first_dest: got %0d want 5", iss_regdest); end
        n_cmp++; if (iss_stall !== 1'b1) begin n_err++; $display("FAIL raw_stall: got %b want 1", iss_stall); end
        tick();
        n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL raw_no_issue: got %b want 0", iss_valid); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL raw_count: got %0d want 1", count); end
        wb_valid = 1'b1; wb_addr = 5'd5;
        #1;
        n_cmp++; if (iss_stall !== !BYP) begin n_err++; $display("FAIL raw_wb_stall: got %b want %b", iss_stall, !BYP); end
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (iss_valid !== BYP) begin n_err++; $display("FAIL raw_wake1: got %b want %b", iss_valid, BYP); end
        n_cmp++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL raw_stall_clear: got %b want 0", iss_stall); end
        n_cmp++; if (dut.u_sb.pending[5] !== 1'b0) begin n_err++; $display("FAIL raw_pending5: got %b want 0", dut.u_sb.pending[5]); end
        tick();
        n_cmp++; if (iss_valid !== !BYP) begin n_err++; $display("FAIL raw_wake2: got %b want %b", iss_valid, !BYP); end
        n_cmp++; if (iss_regdest !== 5'd6) begin n_err++; $display("FAIL raw_second_dest: got %0d want 6", iss_regdest); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL raw_drained: got %0d want 0", count); end
    endtask

    task automatic test_fu_none();
        do_reset();
        fu_ready = 3'b000;
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 2'd3, 96'h33);
        tick();
        idle();
        n_cmp++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL fu3_stall: got %b want 0", iss_stall); end
        tick();
        n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL fu3_issue: got %b want 1", iss_valid); end
        n_cmp++; if (iss_fu !== 2'd3) begin n_err++; $display("FAIL fu3_code: got %0d want 3", iss_fu); end
        fu_ready = 3'b011;
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 2'd2, 96'h44);
        tick();
        idle();
        n_cmp++; if (iss_stall !== 1'b1) begin n_err++; $display("FAIL fu2_stall: got %b want 1", iss_stall); end
        tick();
        n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL fu2_blocked: got %b want 0", iss_valid); end
        fu_ready = 3'b100;
        tick();
        n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL fu2_issue: got %b want 1", iss_valid); end
        n_cmp++; if (iss_fu !== 2'd2) begin n_err++; $display("FAIL fu2_code: got %0d want 2", iss_fu); end
    endtask

    task automatic test_full_drain();
        do_reset();
        fu_ready = 3'b000;
        for (int i = 0; i < 5; i++) begin
            offer(5'd0, 5'd0, 1'b0, 1'b0, 5'(10 + i), 1'b0, 2'd0, 96'(i));
            n_cmp++; if (id_ready !== (i < 4)) begin n_err++; $display("FAIL full_ready_%0d: got %b want %b", i, id_ready, (i < 4)); end
            tick();
        end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count); end
        n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", id_ready); end
        n_cmp++; if (iss_stall !== 1'b1) begin n_err++; $display("FAIL full_stall: got %b want 1", iss_stall); end
        // Entry 4 is still offered while the head drains
        fu_ready = 3'b001;
        tick();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL full_issue_noacc: got %0d want 3", count); end
        n_cmp++; if (iss_regdest !== 5'd10) begin n_err++; $display("FAIL drain_0: got %0d want 10", iss_regdest); end
        tick();
        idle();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL full_acc_and_issue: got %0d want 3", count); end
        n_cmp++; if (iss_regdest !== 5'd11) begin n_err++; $display("FAIL drain_1: got %0d want 11", iss_regdest); end
        for (int k = 2; k < 5; k++) begin
            tick();
            n_cmp++; if (iss_valid !== 1'b1 || iss_regdest !== 5'(10 + k)) begin n_err++; $display("FAIL drain_%0d: got v=%b d=%0d want v=1 d=%0d", k, iss_valid, iss_regdest, 10 + k); end
            n_cmp++; if (count !== 3'(4 - k)) begin n_err++; $display("FAIL drain_count_%0d: got %0d want %0d", k, count, 4 - k); end
        end
        n_cmp++; if (iss_payload !== 96'd4) begin n_err++; $display("FAIL wrap_payload: got %h want 4", iss_payload); end
        tick();
        n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL drain_done: got %b want 0", iss_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        fu_ready = 3'b001;
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'd0, 96'h55);
        tick();
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd20, 1'b0, 2'd1, 96'h66);
        tick();
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd21, 1'b0, 2'd1, 96'h77);
        tick();
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd22, 1'b0, 2'd1, 96'h88);
        tick();
        idle();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush = 1'b1;
        fu_ready = 3'b111;
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd23, 1'b0, 2'd0, 96'h99);
        tick();
        idle();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL flush_iss_valid: got %b want 0", iss_valid); end
        n_cmp++; if (dut.u_sb.pending[9] !== 1'b1) begin n_err++; $display("FAIL flush_pending9: got %b want 1", dut.u_sb.pending[9]); end
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", id_ready); end
        tick();
        n_cmp++; if (iss_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL flush_after: got v=%b c=%0d want v=0 c=0", iss_valid, count); end
    endtask

    task automatic test_set_clear();
        do_reset();
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'd0, 96'hAA);
        tick();
        idle();
        wb_valid = 1'b1; wb_addr = 5'd7;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL sc_issue: got %b want 1", iss_valid); end
        n_cmp++; if (dut.u_sb.pending[7] !== 1'b1) begin n_err++; $display("FAIL sc_pending7: got %b want 1", dut.u_sb.pending[7]); end
        offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd0, 96'hBB);
        tick();
        offer(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 2'd0, 96'hCC);
        tick();
        idle();
        n_cmp++; if (iss_valid !== 1'b1 || iss_regdest !== 5'd0) begin n_err++; $display("FAIL r0_issue: got v=%b d=%0d want v=1 d=0", iss_valid, iss_regdest); end
        n_cmp++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %b want 0", iss_stall); end
        n_cmp++; if (dut.u_sb.pending[0] !== 1'b0) begin n_err++; $display("FAIL r0_pending: got %b want 0", dut.u_sb.pending[0]); end
        tick();
        n_cmp++; if (iss_valid !== 1'b1 || iss_payload !== 96'hCC) begin n_err++; $display("FAIL r0_second: got v=%b p=%h want v=1 p=cc", iss_valid, iss_payload); end
        n_cmp++; if (dut.u_sb.pending !== 32'h0000_0080) begin n_err++; $display("FAIL sc_pending_all: got %h want 00000080", dut.u_sb.pending); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_raw();
        test_fu_none();
        test_full_drain();
        test_flush();
        test_set_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
